// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: NOP encoding,
// multdiv stall-policy encodings and the stall counter width.
package hazard_pkg;

  localparam int STALL_CNT_W = 16;

  localparam int MD_MODE_BUSY = 0;
  localparam int MD_MODE_DEP  = 1;

  // Wide enough for any supported instruction width; sliced to IR_W at use.
  localparam int NOP_MAX_W = 64;
  localparam logic [NOP_MAX_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/md_tracker.sv
// Tracks one in-flight mult/div: busy flag, destination register,
// a watchdog counter and a sticky timeout flag.
module md_tracker #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic [REG_W-1:0] rd_dx,
  output logic             md_busy,
  output logic [REG_W-1:0] md_rd,
  output logic             md_timeout
);

  localparam int CNT_W = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LAT - 1);

  logic [CNT_W-1:0] mdCnt;

  // md_start and md_ready are single-cycle pulses with no back-pressure;
  // md_ready is only honoured while busy, and a start landing together
  // with a ready is a clear-then-set that restarts the watchdog.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_busy    <= 1'b0;
      md_rd      <= '0;
      mdCnt      <= '0;
      md_timeout <= 1'b0;
    end else if (md_start) begin
      md_busy <= 1'b1;
      md_rd   <= rd_dx;
      mdCnt   <= '0;
    end else if (md_busy) begin
      if (md_ready) begin
        md_busy <= 1'b0;
        mdCnt   <= '0;
      end else if (mdCnt == CNT_LAST) begin
        md_busy    <= 1'b0;
        md_timeout <= 1'b1;
        mdCnt      <= '0;
      end else begin
        mdCnt <= mdCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and multdiv stalls, DX bubble
// insertion on stall/flush/write-to-r0, and a saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int IR_W     = 32,
  parameter int MD_LAT   = 32,
  parameter int LOAD_LAT = 1,
  parameter int MD_MODE  = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [IR_W-1:0]        ir_fd,
  input  logic [REG_W-1:0]       rs_fd,
  input  logic [REG_W-1:0]       rt_fd,
  input  logic [REG_W-1:0]       rd_fd,
  input  logic                   rtype_fd,
  input  logic                   we_fd,
  input  logic                   md_fd,
  input  logic                   branch_taken,
  input  logic                   lw_dx,
  input  logic [REG_W-1:0]       rd_dx,
  input  logic                   md_start,
  input  logic                   md_ready,
  output logic                   stall,
  output logic [IR_W-1:0]        ir_dx,
  output logic                   md_busy,
  output logic [REG_W-1:0]       md_rd,
  output logic                   md_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  function automatic logic srcHit(input logic [REG_W-1:0] r,
                                  input logic [REG_W-1:0] rs,
                                  input logic [REG_W-1:0] rt,
                                  input logic             rtype);
    return (r != '0) && ((r == rs) || (rtype && (r == rt)));
  endfunction

  logic             lwXmQ;
  logic [REG_W-1:0] rdXmQ;
  logic             hitDx;
  logic             hitXm;
  logic             loadHaz;
  logic             mdHazBusy;
  logic             mdHazDep;
  logic             mdHaz;
  logic             wrZero;

  md_tracker #(
    .REG_W (REG_W),
    .MD_LAT(MD_LAT)
  ) u_md_tracker (
    .clock     (clock),
    .reset_n   (reset_n),
    .md_start  (md_start),
    .md_ready  (md_ready),
    .rd_dx     (rd_dx),
    .md_busy   (md_busy),
    .md_rd     (md_rd),
    .md_timeout(md_timeout)
  );

  // Second load-use stage; a stalled cycle hands XM a bubble, not the load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lwXmQ <= 1'b0;
      rdXmQ <= '0;
    end else begin
      lwXmQ <= lw_dx & ~stall;
      rdXmQ <= rd_dx;
    end
  end

  always_comb begin
    hitDx     = lw_dx & srcHit(rd_dx, rs_fd, rt_fd, rtype_fd);
    hitXm     = lwXmQ & srcHit(rdXmQ, rs_fd, rt_fd, rtype_fd);
    loadHaz   = (LOAD_LAT == 2) ? (hitDx | hitXm) : hitDx;

    mdHazBusy = md_start | md_busy;
    mdHazDep  = (md_busy & (srcHit(md_rd, rs_fd, rt_fd, rtype_fd) | md_fd |
                            (we_fd & (rd_fd == md_rd)))) |
                (md_start & (srcHit(rd_dx, rs_fd, rt_fd, rtype_fd) | md_fd));
    case (MD_MODE)
      MD_MODE_BUSY: mdHaz = mdHazBusy;
      MD_MODE_DEP:  mdHaz = mdHazDep;
      default:      mdHaz = mdHazBusy;
    endcase

    stall  = loadHaz | mdHaz;
    wrZero = we_fd & (rd_fd == '0);
    ir_dx  = (stall | branch_taken | wrZero) ? NOP_WORD[IR_W-1:0] : ir_fd;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three parameterisations share one input
// set (A: defaults, B: dependency mode + two-deep load-use, C: MD_LAT=4).
module tb_hazard_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] ir_fd;
  logic [4:0]  rs_fd, rt_fd, rd_fd, rd_dx;
  logic        rtype_fd, we_fd, md_fd, branch_taken, lw_dx, md_start, md_ready;

  logic        stallA, stallB, stallC;
  logic [31:0] irDxA, irDxB, irDxC;
  logic        busyA, busyB, busyC;
  logic [4:0]  mdRdA, mdRdB, mdRdC;
  logic        timeoutA, timeoutB, timeoutC;
  logic [15:0] cyclesA, cyclesB, cyclesC;

  int checkCount = 0;
  int errorCount = 0;

  hazard_ctrl u_dut_a (
    .clock(clock), .reset_n(reset_n), .ir_fd(ir_fd), .rs_fd(rs_fd), .rt_fd(rt_fd),
    .rd_fd(rd_fd), .rtype_fd(rtype_fd), .we_fd(we_fd), .md_fd(md_fd),
    .branch_taken(branch_taken), .lw_dx(lw_dx), .rd_dx(rd_dx), .md_start(md_start),
    .md_ready(md_ready), .stall(stallA), .ir_dx(irDxA), .md_busy(busyA), .md_rd(mdRdA),
    .md_timeout(timeoutA), .stall_cycles(cyclesA)
  );

  hazard_ctrl #(.MD_MODE(1), .LOAD_LAT(2)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .ir_fd(ir_fd), .rs_fd(rs_fd), .rt_fd(rt_fd),
    .rd_fd(rd_fd), .rtype_fd(rtype_fd), .we_fd(we_fd), .md_fd(md_fd),
    .branch_taken(branch_taken), .lw_dx(lw_dx), .rd_dx(rd_dx), .md_start(md_start),
    .md_ready(md_ready), .stall(stallB), .ir_dx(irDxB), .md_busy(busyB), .md_rd(mdRdB),
    .md_timeout(timeoutB), .stall_cycles(cyclesB)
  );

  hazard_ctrl #(.MD_LAT(4)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .ir_fd(ir_fd), .rs_fd(rs_fd), .rt_fd(rt_fd),
    .rd_fd(rd_fd), .rtype_fd(rtype_fd), .we_fd(we_fd), .md_fd(md_fd),
    .branch_taken(branch_taken), .lw_dx(lw_dx), .rd_dx(rd_dx), .md_start(md_start),
    .md_ready(md_ready), .stall(stallC), .ir_dx(irDxC), .md_busy(busyC), .md_rd(mdRdC),
    .md_timeout(timeoutC), .stall_cycles(cyclesC)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver tasks: inputs change just after the falling edge, checks #1 later.
  task automatic idle();
    rs_fd = '0; rt_fd = '0; rd_fd = '0; rd_dx = '0;
    rtype_fd = 1'b0; we_fd = 1'b0; md_fd = 1'b0; branch_taken = 1'b0;
    lw_dx = 1'b0; md_start = 1'b0; md_ready = 1'b0;
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    ir_fd = 32'h1234_5678;
    #3;
    checkCount++; if (busyA !== 1'b0 || busyB !== 1'b0 || busyC !== 1'b0) begin
      errorCount++; $display("FAIL reset_busy: got %b%b%b expected 000", busyA, busyB, busyC); end
    checkCount++; if (mdRdA !== 5'd0 || timeoutA !== 1'b0 || cyclesA !== 16'd0) begin
      errorCount++; $display("FAIL reset_regs: got rd=%0d to=%b cyc=%0d expected 0 0 0", mdRdA, timeoutA, cyclesA); end
    checkCount++; if (stallA !== 1'b0 || irDxA !== 32'h1234_5678) begin
      errorCount++; $display("FAIL reset_pass: got stall=%b ir=%h expected 0 12345678", stallA, irDxA); end
    lw_dx = 1'b1; rd_dx = 5'd5; rs_fd = 5'd5;
    #1;
    checkCount++; if (stallA !== 1'b1 || irDxA !== 32'h0) begin
      errorCount++; $display("FAIL reset_comb_load: got stall=%b ir=%h expected 1 0", stallA, irDxA); end
    idle();
    nextCycle();
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    nextCycle(); idle();
    ir_fd = 32'hDEAD_BEEF; lw_dx = 1'b1; rd_dx = 5'd5; rs_fd = 5'd5;
    #1;
    checkCount++; if (stallA !== 1'b1 || irDxA !== 32'h0) begin
      errorCount++; $display("FAIL load_hit_rs: got stall=%b ir=%h expected 1 0", stallA, irDxA); end
    rd_dx = 5'd0; rs_fd = 5'd0;
    #1;
    checkCount++; if (stallA !== 1'b0 || irDxA !== 32'hDEAD_BEEF) begin
      errorCount++; $display("FAIL load_r0: got stall=%b ir=%h expected 0 deadbeef", stallA, irDxA); end
    nextCycle();
    rd_dx = 5'd5; rt_fd = 5'd5; rtype_fd = 1'b0;
    #1;
    checkCount++; if (stallA !== 1'b0) begin
      errorCount++; $display("FAIL load_rt_itype: got %b expected 0", stallA); end
    rtype_fd = 1'b1;
    #1;
    checkCount++; if (stallA !== 1'b1) begin
      errorCount++; $display("FAIL load_rt_rtype: got %b expected 1", stallA); end
    // Two-deep load-use on B
    nextCycle(); idle();
    lw_dx = 1'b1; rd_dx = 5'd9; rs_fd = 5'd1; rt_fd = 5'd2;
    #1;
    checkCount++; if (stallB !== 1'b0 || stallA !== 1'b0) begin
      errorCount++; $display("FAIL load2_dx_nohit: got A=%b B=%b expected 0 0", stallA, stallB); end
    nextCycle();
    lw_dx = 1'b0; rd_dx = 5'd0; rs_fd = 5'd9;
    #1;
    checkCount++; if (stallB !== 1'b1 || stallA !== 1'b0) begin
      errorCount++; $display("FAIL load2_xm_hit: got A=%b B=%b expected 0 1", stallA, stallB); end
    nextCycle();
    #1;
    checkCount++; if (stallB !== 1'b0) begin
      errorCount++; $display("FAIL load2_bubble: got %b expected 0", stallB); end
  endtask

  task automatic test_md_mode0();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    md_start = 1'b1; rd_dx = 5'd7;
    #1;
    checkCount++; if (stallA !== 1'b1) begin
      errorCount++; $display("FAIL md0_start_stall: got %b expected 1", stallA); end
    for (int k = 1; k <= 10; k++) begin
      nextCycle();
      md_start = 1'b0; rd_dx = 5'd0; md_ready = (k == 10);
      #1;
      checkCount++; if (busyA !== 1'b1 || stallA !== 1'b1) begin
        errorCount++; $display("FAIL md0_busy_c%0d: got busy=%b stall=%b expected 1 1", k, busyA, stallA); end
      if (k == 1) begin
        checkCount++; if (mdRdA !== 5'd7) begin
          errorCount++; $display("FAIL md0_rd: got %0d expected 7", mdRdA); end
      end
    end
    nextCycle();
    md_ready = 1'b0;
    #1;
    checkCount++; if (busyA !== 1'b0 || stallA !== 1'b0) begin
      errorCount++; $display("FAIL md0_done: got busy=%b stall=%b expected 0 0", busyA, stallA); end
    checkCount++; if (cyclesA !== 16'd11) begin
      errorCount++; $display("FAIL md0_stall_cycles: got %0d expected 11", cyclesA); end
  endtask

  task automatic test_md_mode1();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    md_start = 1'b1; rd_dx = 5'd7; rs_fd = 5'd3;
    #1;
    checkCount++; if (stallB !== 1'b0) begin
      errorCount++; $display("FAIL md1_start_indep: got %b expected 0", stallB); end
    nextCycle();
    md_start = 1'b0; rd_dx = 5'd0;
    #1;
    checkCount++; if (busyB !== 1'b1 || mdRdB !== 5'd7 || stallB !== 1'b0) begin
      errorCount++; $display("FAIL md1_busy_indep: got busy=%b rd=%0d stall=%b expected 1 7 0", busyB, mdRdB, stallB); end
    nextCycle();
    md_fd = 1'b1;
    #1;
    checkCount++; if (stallB !== 1'b1) begin
      errorCount++; $display("FAIL md1_md_fd: got %b expected 1", stallB); end
    nextCycle();
    md_fd = 1'b0; we_fd = 1'b1; rd_fd = 5'd7;
    #1;
    checkCount++; if (stallB !== 1'b1) begin
      errorCount++; $display("FAIL md1_waw: got %b expected 1", stallB); end
    nextCycle();
    we_fd = 1'b0; rd_fd = 5'd0; rt_fd = 5'd7; rtype_fd = 1'b0;
    #1;
    checkCount++; if (stallB !== 1'b0) begin
      errorCount++; $display("FAIL md1_rt_itype: got %b expected 0", stallB); end
    rtype_fd = 1'b1;
    #1;
    checkCount++; if (stallB !== 1'b1) begin
      errorCount++; $display("FAIL md1_rt_rtype: got %b expected 1", stallB); end
    nextCycle();
    md_ready = 1'b1;
    #1;
    checkCount++; if (stallB !== 1'b1) begin
      errorCount++; $display("FAIL md1_ready_cycle: got %b expected 1", stallB); end
    nextCycle();
    md_ready = 1'b0;
    #1;
    checkCount++; if (stallB !== 1'b0 || busyB !== 1'b0) begin
      errorCount++; $display("FAIL md1_released: got stall=%b busy=%b expected 0 0", stallB, busyB); end
  endtask

  task automatic test_timeout();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    md_start = 1'b1; rd_dx = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      md_start = 1'b0; rd_dx = 5'd0;
      #1;
      checkCount++; if (busyC !== 1'b1 || timeoutC !== 1'b0) begin
        errorCount++; $display("FAIL to_busy_c%0d: got busy=%b to=%b expected 1 0", k, busyC, timeoutC); end
    end
    nextCycle();
    #1;
    checkCount++; if (busyC !== 1'b0 || timeoutC !== 1'b1) begin
      errorCount++; $display("FAIL to_expire: got busy=%b to=%b expected 0 1", busyC, timeoutC); end
    nextCycle(); md_ready = 1'b1;
    repeat (3) nextCycle();
    md_ready = 1'b0;
    #1;
    checkCount++; if (timeoutC !== 1'b1 || busyC !== 1'b0) begin
      errorCount++; $display("FAIL to_sticky: got to=%b busy=%b expected 1 0", timeoutC, busyC); end
  endtask

  task automatic test_back_to_back();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    md_start = 1'b1; rd_dx = 5'd4;
    nextCycle();
    md_start = 1'b0; rd_dx = 5'd0;
    nextCycle();
    nextCycle();
    md_start = 1'b1; md_ready = 1'b1; rd_dx = 5'd12;
    nextCycle();
    md_start = 1'b0; md_ready = 1'b0; rd_dx = 5'd0;
    #1;
    checkCount++; if (busyC !== 1'b1 || mdRdC !== 5'd12 || busyA !== 1'b1 || mdRdA !== 5'd12) begin
      errorCount++; $display("FAIL b2b_reload: got C=%b/%0d A=%b/%0d expected 1/12 1/12", busyC, mdRdC, busyA, mdRdA); end
    repeat (3) nextCycle();
    #1;
    checkCount++; if (busyC !== 1'b1 || timeoutC !== 1'b0) begin
      errorCount++; $display("FAIL b2b_restart: got busy=%b to=%b expected 1 0", busyC, timeoutC); end
    nextCycle();
    #1;
    checkCount++; if (busyC !== 1'b0 || timeoutC !== 1'b1) begin
      errorCount++; $display("FAIL b2b_expire: got busy=%b to=%b expected 0 1", busyC, timeoutC); end
  endtask

  task automatic test_branch_nop();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    ir_fd = 32'hCAFE_0001; branch_taken = 1'b1;
    #1;
    checkCount++; if (irDxA !== 32'h0 || stallA !== 1'b0) begin
      errorCount++; $display("FAIL br_flush: got ir=%h stall=%b expected 0 0", irDxA, stallA); end
    branch_taken = 1'b0; we_fd = 1'b1; rd_fd = 5'd0;
    #1;
    checkCount++; if (irDxA !== 32'h0) begin
      errorCount++; $display("FAIL wr_r0_nop: got %h expected 0", irDxA); end
    nextCycle();
    rd_fd = 5'd3;
    #1;
    checkCount++; if (irDxA !== 32'hCAFE_0001) begin
      errorCount++; $display("FAIL wr_r3_pass: got %h expected cafe0001", irDxA); end
    we_fd = 1'b0; lw_dx = 1'b1; rd_dx = 5'd5; rs_fd = 5'd5; branch_taken = 1'b1;
    #1;
    checkCount++; if (stallA !== 1'b1 || irDxA !== 32'h0) begin
      errorCount++; $display("FAIL br_and_stall: got stall=%b ir=%h expected 1 0", stallA, irDxA); end
  endtask

  task automatic test_reset_mid_md();
    nextCycle(); idle(); pulseReset();
    nextCycle();
    md_start = 1'b1; rd_dx = 5'd7;
    nextCycle();
    md_start = 1'b0; rd_dx = 5'd0;
    nextCycle();
    nextCycle();
    #1;
    checkCount++; if (busyA !== 1'b1) begin
      errorCount++; $display("FAIL mid_pre_busy: got %b expected 1", busyA); end
    reset_n = 1'b0;
    #1;
    checkCount++; if (busyA !== 1'b0 || mdRdA !== 5'd0) begin
      errorCount++; $display("FAIL mid_async_clear: got busy=%b rd=%0d expected 0 0", busyA, mdRdA); end
    #1;
    reset_n = 1'b1;
    nextCycle();
    md_ready = 1'b1;
    nextCycle();
    md_ready = 1'b0;
    #1;
    checkCount++; if (busyA !== 1'b0 || stallA !== 1'b0 || timeoutA !== 1'b0) begin
      errorCount++; $display("FAIL mid_late_ready: got busy=%b stall=%b to=%b expected 0 0 0", busyA, stallA, timeoutA); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md_mode0();
    test_md_mode1();
    test_timeout();
    test_back_to_back();
    test_branch_nop();
    test_reset_mid_md();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL be clocked by one clock and reset asynchronously, active-low.
REQ-002 Parameters (name, default, meaning), SHALL be one per line:
- REG_W, 5, register-address width.
- IR_W, 32, instruction width.
- MD_LAT, 32, multdiv timeout in cycles (>=2).
- LOAD_LAT, 1, load-use bubble depth (1 or 2).
- MD_MODE, 0, multdiv stall policy: 0 = stall while busy; 1 = stall only on dependency.
REQ-003 Ports (name, direction, width, meaning), SHALL be one per line:
- clock, in, 1, clock.
- reset_n, in, 1, async active-low reset.
- ir_fd, in, IR_W, FD instruction.
- rs_fd / rt_fd / rd_fd, in, REG_W, FD register fields.
- rtype_fd, in, 1, FD is R-type (rt is a source).
- we_fd, in, 1, FD writes rd.
- md_fd, in, 1, FD is mult/div.
- branch_taken, in, 1, flush request.
- lw_dx, in, 1, DX is load.
- rd_dx, in, REG_W, DX destination.
- md_start, in, 1, mult/div issuing from DX.
- md_ready, in, 1, multdiv result-valid pulse.
- stall, out, 1, freeze PC and FD.
- ir_dx, out, IR_W, instruction into DX.
- md_busy, out, 1, multdiv in flight.
- md_rd, out, REG_W, in-flight multdiv destination.
- md_timeout, out, 1, sticky timeout flag.
- stall_cycles, out, 16, saturating stall count.

Function
REQ-004 src_hit(r) SHALL be true only when r != 0 and (r == rs_fd, or r == rt_fd with rtype_fd=1).
REQ-005 When LOAD_LAT=1, load_haz SHALL be lw_dx & src_hit(rd_dx), computed combinationally.
REQ-006 When LOAD_LAT=2, the block SHALL register lw_dx/rd_dx each cycle and set load_haz = (lw_dx & src_hit(rd_dx)) | (lw_xm_q & src_hit(rd_xm_q)); when stall=1, the registered copy SHALL capture lw=0.
REQ-007 md_busy SHALL be set the cycle after md_start and SHALL capture md_rd <= rd_dx at the same edge.
REQ-008 md_busy SHALL clear on the edge where md_ready=1 or where the cycle counter reaches MD_LAT; on a counter expiry, md_timeout SHALL set and hold until reset.
REQ-009 When md_start and md_ready occur in the same cycle, the block SHALL treat it as clear-then-set: md_busy stays 1, the counter restarts at 0, and md_rd is reloaded.
REQ-010 In MD_MODE=0, md_haz SHALL be md_start | md_busy.
REQ-011 In MD_MODE=1, md_haz SHALL be (md_busy & (src_hit(md_rd) | md_fd | (we_fd & rd_fd == md_rd))) | (md_start & (src_hit(rd_dx) | md_fd)).
REQ-012 stall SHALL be load_haz | md_haz, combinational with zero latency.
REQ-013 ir_dx SHALL be all-zero (NOP) when stall | branch_taken | (we_fd & rd_fd == 0), and SHALL equal ir_fd otherwise.
REQ-014 When stall and branch_taken coincide, stall SHALL be 1 and ir_dx SHALL be NOP.
REQ-015 stall_cycles SHALL increment on each edge with stall=1 and saturate at 16'hFFFF.

Reset
REQ-016 While reset_n=0, md_busy, md_rd, the counter, md_timeout, stall_cycles and the LOAD_LAT=2 registers SHALL all be 0, and stall SHALL depend only on the combinational load_haz/md_start terms.
REQ-017 A reset asserted mid-multdiv SHALL abandon the operation immediately; after deassertion, a late md_ready SHALL be ignored while md_busy=0.

Structure
REQ-018 Package hazard_pkg SHALL hold the NOP constant, the MD_MODE encodings and the stall_cycles width.
REQ-019 A sub-module md_tracker SHALL hold the busy flag, the md_rd register, the MD_LAT counter and the timeout flag.

Verification
REQ-020 The bench SHALL cover these scenarios:
- LOAD_LAT=1, lw_dx=1, rd_dx=5, rs_fd=5 -> stall=1, ir_dx=0; same with rd_dx=0 -> stall=0, ir_dx=ir_fd.
- MD_MODE=0: md_start with rd_dx=7, md_ready 10 cycles later -> stall=1 for 11 cycles, md_busy=1 for 10, stall_cycles=11.
- MD_MODE=1: busy with md_rd=7; FD uses rs=3 -> stall=0; FD uses rt=7 with rtype_fd=1 -> stall=1 until md_ready.
- MD_LAT=4, md_ready never arrives -> md_busy clears 4 cycles after set, md_timeout=1 and stays 1.
- branch_taken=1 with no hazard -> ir_dx=0, stall=0; we_fd=1 with rd_fd=0 -> ir_dx=0.
- reset_n pulsed low mid-multdiv -> md_busy=0 asynchronously; a subsequent md_ready has no effect.
